// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM encoding, NOP word, PC step and the IF/ID bundle.
package fetch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic [31:0] inc_pc(input logic [31:0] p);
        return p + PC_INCR;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register; priority flush > stall > load, else bubble.
// Ports: clk, rst, load, flush, stall, data in; instr, pc_plus4, valid out.
import fetch_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        stall,
    input  if_id_t      data,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // A bubble keeps pc_plus4 so downstream sees a stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (stall) begin
            instr <= instr;
        end else if (load) begin
            instr    <= data.instr;
            pc_plus4 <= data.pc_plus4;
            valid    <= 1'b1;
        end else begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, imem handshake (one outstanding), skid, IF/ID.
// Ports: clk, rst, imem_req/addr/ack/rdata, stall_id, branch_taken/
// branch_target, jump/jump_target, pc, if_id_instr/pc_plus4/valid.
// Macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles outputs.
import fetch_pkg::*;

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    input  logic            stall_id,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] if_id_instr,
    output logic [PC_W-1:0] if_id_pc_plus4,
    output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    logic [1:0]      state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] drain_addr, drain_n;
    logic [PC_W-1:0] skid_instr, skid_n;
    logic            redirect;
    logic [PC_W-1:0] target;
    logic            ld;
    if_id_t          ld_data;

    assign redirect = branch_taken | jump;
    // Branch comes from the older instruction, so it wins.
    assign target   = branch_taken ? branch_target : jump_target;

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    // While draining, the bus must stay on the abandoned address.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        state_n          = state;
        pc_n             = pc;
        drain_n          = drain_addr;
        skid_n           = skid_instr;
        ld               = 1'b0;
        ld_data.instr    = imem_rdata;
        ld_data.pc_plus4 = inc_pc(pc);
        unique case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_n = imem_ack ? FETCH : DRAIN;
                    drain_n = pc;
                end else if (imem_ack) begin
                    if (stall_id) begin
                        skid_n  = imem_rdata;
                        state_n = HOLD;
                    end else begin
                        ld   = 1'b1;
                        pc_n = inc_pc(pc);
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_n = FETCH;
                end else if (!stall_id) begin
                    ld            = 1'b1;
                    ld_data.instr = skid_instr;
                    pc_n          = inc_pc(pc);
                    state_n       = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) state_n = FETCH;
            end
            default: state_n = IDLE;
        endcase
        if (redirect) pc_n = target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            skid_instr <= NOP_INSTR;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_n;
            skid_instr <= skid_n;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .flush    (redirect),
        .stall    (stall_id),
        .data     (ld_data),
        .instr    (if_id_instr),
        .pc_plus4 (if_id_pc_plus4),
        .valid    (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic bubble;
    assign bubble = redirect || (!stall_id && !ld);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (ld)     perf_fetched <= perf_fetched + 32'd1;
            if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
